// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package memory_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic M_CORE  = 1'b0;
  localparam logic M_DEBUG = 1'b1;

  // One buffered memory request as held in a request slot.
  typedef struct packed {
    logic              command;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [MASK_W-1:0] write_mask;
  } mem_req_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Ready/enable/command/valid memory handshake, used on both master and memory sides.
interface memory_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  logic                  ready;
  logic                  enable;
  logic                  command;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [MASK_WIDTH-1:0] write_mask;
  logic                  valid;
  logic [DATA_WIDTH-1:0] read_data;

  // Requester side: issues commands, receives ready/valid/read_data.
  modport master (
    input  ready, valid, read_data,
    output enable, command, address, write_data, write_mask
  );

  // Responder side: accepts commands, returns ready/valid/read_data.
  modport slave (
    output ready, valid, read_data,
    input  enable, command, address, write_data, write_mask
  );

endinterface

// File: rtl/memory_arbiter_request_slot.sv
// One-entry request buffer: full flag plus latched payload.
module request_slot
  import memory_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     clear,
  input  mem_req_t req,
  output logic     full,
  output mem_req_t payload
);

  // load is only raised while empty and clear only while full, so they never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full    <= 1'b0;
      payload <= '0;
    end else begin
      if (clear) begin
        full <= 1'b0;
      end else if (load) begin
        full <= 1'b1;
      end
      if (load) begin
        payload <= req;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (m0) and debug (m1) masters.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input logic              clk,
  input logic              reset,
  memory_arbiter_if.slave  m0,
  memory_arbiter_if.slave  m1,
  memory_arbiter_if.master memory
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  arb_state_t            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  rr_q, rr_d;
  logic                  full0, full1;
  logic                  load0, load1;
  logic                  clear0, clear1;
  logic                  resp_fire;
  logic                  issuing;
  mem_req_t              req0, req1, slot0, slot1, sel;
  logic                  valid0_q, valid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  assign load0     = m0.enable & ~full0;
  assign load1     = m1.enable & ~full1;
  assign resp_fire = (state_q == WAIT) & memory.valid;
  assign clear0    = resp_fire & (owner_q == M_CORE);
  assign clear1    = resp_fire & (owner_q == M_DEBUG);

  assign req0 = '{command:    m0.command,
                  address:    ADDR_W'(m0.address),
                  write_data: DATA_W'(m0.write_data),
                  write_mask: MASK_W'(m0.write_mask)};
  assign req1 = '{command:    m1.command,
                  address:    ADDR_W'(m1.address),
                  write_data: DATA_W'(m1.write_data),
                  write_mask: MASK_W'(m1.write_mask)};

  request_slot u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .load    (load0),
    .clear   (clear0),
    .req     (req0),
    .full    (full0),
    .payload (slot0)
  );

  request_slot u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .load    (load1),
    .clear   (clear1),
    .req     (req1),
    .full    (full1),
    .payload (slot1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= M_CORE;
      rr_q    <= M_CORE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Owner is the single full slot, or rr_q when both are waiting.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (full0 | full1) begin
          state_d = ISSUE;
          if (full0 & full1) begin
            owner_d = rr_q;
          end else begin
            owner_d = full1 ? M_DEBUG : M_CORE;
          end
        end
      end
      ISSUE: begin
        if (memory.ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (memory.valid) begin
          state_d = IDLE;
          rr_d    = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command fields come straight from the owner's slot, so they stay stable while stalled.
  assign sel               = (owner_q == M_DEBUG) ? slot1 : slot0;
  assign issuing           = (state_q == ISSUE);
  assign memory.enable     = issuing & memory.ready;
  assign memory.command    = issuing ? sel.command : MEM_READ;
  assign memory.address    = issuing ? ADDR_WIDTH'(sel.address) : '0;
  assign memory.write_data = issuing ? DATA_WIDTH'(sel.write_data) : '0;
  assign memory.write_mask = issuing ? MASK_WIDTH'(sel.write_mask) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      valid0_q <= clear0;
      valid1_q <= clear1;
      if (clear0) begin
        rdata0_q <= memory.read_data;
      end
      if (clear1) begin
        rdata1_q <= memory.read_data;
      end
    end
  end

  assign m0.ready     = ~full0;
  assign m1.ready     = ~full1;
  assign m0.valid     = valid0_q;
  assign m1.valid     = valid1_q;
  assign m0.read_data = rdata0_q;
  assign m1.read_data = rdata1_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected memory commands queued at stimulus time.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;

  logic clk;
  logic reset;

  memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
  memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .m0     (m0_if),
    .m1     (m1_if),
    .memory (mem_if)
  );

  typedef struct {
    logic          master;
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
  } exp_t;

  exp_t exp_mem[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fire_cnt = 0;
  int fire_cyc = 0;
  int acc_cyc0 = 0;
  int valid_cyc = 0;
  int valid_cnt[2];
  int m0_at_m1 = 0;
  int resp_delay = 3;
  int mdl_cnt = 0;
  logic mdl_pend = 1'b0;
  logic [DW-1:0] mdl_data = '0;
  logic stray = 1'b0;
  logic resp_pending = 1'b0;
  logic resp_master = 1'b0;
  logic resp_read = 1'b0;
  logic [DW-1:0] resp_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model contents; 0x100 returns the well-known test pattern.
  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic resp_seen(input int m, input logic [DW-1:0] d);
    if (!resp_pending) begin
      check($sformatf("spurious_valid_m%0d", m), 64'd1, 64'd0);
    end else begin
      check("resp_master", 64'(m), 64'(resp_master));
      if (resp_read) check("resp_data", 64'(d), 64'(resp_data));
      resp_pending = 1'b0;
    end
    valid_cnt[m]++;
    valid_cyc = cyc;
    if (m == 1) m0_at_m1 = valid_cnt[0];
  endtask

  // One clock: sample handshakes before the edge, drive the memory model after it, check responses on negedge.
  task automatic tick();
    logic acc0, acc1, fire, v0, v1;
    exp_t e;
    #1;
    acc0 = m0_if.enable && m0_if.ready;
    acc1 = m1_if.enable && m1_if.ready;
    fire = mem_if.enable && mem_if.ready;
    if (acc0) acc_cyc0 = cyc;
    if (fire) begin
      fire_cnt++;
      fire_cyc = cyc;
      if (exp_mem.size() == 0) begin
        check("mem_unexpected_cmd", 64'(mem_if.address), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_mem.pop_front();
        check("mem_command", 64'(mem_if.command), 64'(e.cmd));
        check("mem_address", 64'(mem_if.address), 64'(e.addr));
        check("mem_write_data", 64'(mem_if.write_data), 64'(e.wdata));
        check("mem_write_mask", 64'(mem_if.write_mask), 64'(e.mask));
        resp_pending = 1'b1;
        resp_master  = e.master;
        resp_read    = (e.cmd == MEM_READ);
        resp_data    = mem_data(e.addr);
      end
      mdl_pend = 1'b1;
      mdl_cnt  = resp_delay;
      mdl_data = mem_data(mem_if.address);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc0) m0_if.enable = 1'b0;
    if (acc1) m1_if.enable = 1'b0;
    mem_if.valid = 1'b0;
    if (mdl_pend) begin
      if (mdl_cnt <= 1) begin
        mem_if.valid     = 1'b1;
        mem_if.read_data = mdl_data;
        mdl_pend         = 1'b0;
      end else begin
        mdl_cnt--;
      end
    end
    if (stray) begin
      mem_if.valid     = 1'b1;
      mem_if.read_data = 32'hBAD0_BAD0;
      stray            = 1'b0;
    end
    @(negedge clk);
    v0 = m0_if.valid;
    v1 = m1_if.valid;
    if (v0 || v1) check("valid_onehot", 64'(v0 && v1), 64'd0);
    if (v0) resp_seen(0, m0_if.read_data);
    if (v1) resp_seen(1, m1_if.read_data);
  endtask

  task automatic req(input logic m, input logic cmd, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [MW-1:0] k);
    exp_t e;
    e.master = m;
    e.cmd    = cmd;
    e.addr   = a;
    e.wdata  = d;
    e.mask   = k;
    exp_mem.push_back(e);
    if (m == M_CORE) begin
      m0_if.enable = 1'b1; m0_if.command = cmd; m0_if.address = a;
      m0_if.write_data = d; m0_if.write_mask = k;
    end else begin
      m1_if.enable = 1'b1; m1_if.command = cmd; m1_if.address = a;
      m1_if.write_data = d; m1_if.write_mask = k;
    end
  endtask

  task automatic wait_fire(input string tag, input int budget);
    int b;
    int n;
    b = fire_cnt;
    n = 0;
    while (fire_cnt == b && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(fire_cnt != b), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int m, input int budget);
    int b;
    int n;
    b = valid_cnt[m];
    n = 0;
    while (valid_cnt[m] == b && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(valid_cnt[m] != b), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_mem.delete();
    resp_pending = 1'b0;
    mdl_pend = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int base;
    int base0;
    int base1;
    valid_cnt[0] = 0;
    valid_cnt[1] = 0;
    reset = 1'b0;
    m0_if.enable = 1'b0; m0_if.command = 1'b0; m0_if.address = '0;
    m0_if.write_data = '0; m0_if.write_mask = '0;
    m1_if.enable = 1'b0; m1_if.command = 1'b0; m1_if.address = '0;
    m1_if.write_data = '0; m1_if.write_mask = '0;
    mem_if.ready = 1'b1; mem_if.valid = 1'b0; mem_if.read_data = '0;
    tick();
    tick();
    check("rst_m0_ready", 64'(m0_if.ready), 64'd1);
    check("rst_m1_ready", 64'(m1_if.ready), 64'd1);
    check("rst_m0_valid", 64'(m0_if.valid), 64'd0);
    check("rst_m1_valid", 64'(m1_if.valid), 64'd0);
    check("rst_m0_read_data", 64'(m0_if.read_data), 64'd0);
    check("rst_mem_enable", 64'(mem_if.enable), 64'd0);
    check("rst_mem_address", 64'(mem_if.address), 64'd0);
    check("rst_mem_command", 64'(mem_if.command), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(IDLE));
    reset = 1'b1;
    tick();

    // Single core read with the fixed response pattern.
    resp_delay = 3;
    req(M_CORE, MEM_READ, 32'h100, 32'h0, 4'h0);
    tick();
    wait_fire("t1_fire", 10);
    check("t1_issue_latency", 64'(fire_cyc - acc_cyc0), 64'd2);
    wait_valid("t1_resp", 0, 20);
    check("t1_valid_latency", 64'(valid_cyc - fire_cyc), 64'd4);
    check("t1_m0_data", 64'(m0_if.read_data), 64'hDEAD_BEEF);
    check("t1_m1_valid", 64'(m1_if.valid), 64'd0);
    tick();
    check("t1_valid_pulse", 64'(m0_if.valid), 64'd0);
    check("t1_m0_ready", 64'(m0_if.ready), 64'd1);

    // Simultaneous requests from a fresh reset: core first, twice in a row.
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      base = fire_cnt;
      req(M_CORE, pass == 0 ? MEM_READ : MEM_WRITE, 32'h300 + 32'(pass * 16), 32'hA0 + 32'(pass), 4'hF);
      req(M_DEBUG, pass == 0 ? MEM_READ : MEM_WRITE, 32'h304 + 32'(pass * 16), 32'hB0 + 32'(pass), 4'h5);
      tick();
      wait_valid("t2_m1_resp", 1, 40);
      check("t2_two_enables", 64'(fire_cnt - base), 64'd2);
    end

    // Debug write held off by memory_ready low for five cycles.
    mem_if.ready = 1'b0;
    req(M_DEBUG, MEM_WRITE, 32'h200, 32'h1234_5678, 4'b0011);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t3_stall_enable", 64'(mem_if.enable), 64'd0);
      check("t3_stall_address", 64'(mem_if.address), 64'h200);
      check("t3_stall_command", 64'(mem_if.command), 64'(MEM_WRITE));
      check("t3_stall_data", 64'(mem_if.write_data), 64'h1234_5678);
      check("t3_stall_mask", 64'(mem_if.write_mask), 64'h3);
      tick();
    end
    mem_if.ready = 1'b1;
    base = fire_cnt;
    wait_valid("t3_resp", 1, 20);
    check("t3_single_pulse", 64'(fire_cnt - base), 64'd1);

    // Core streams back-to-back requests; the waiting debug request must not starve.
    resp_delay = 2;
    req(M_CORE, MEM_READ, 32'h400, 32'h0, 4'h0);
    tick();
    tick();
    base0 = valid_cnt[0];
    base1 = valid_cnt[1];
    req(M_DEBUG, MEM_READ, 32'h500, 32'h0, 4'h0);
    for (int n = 1; n <= 3; n++) begin
      wait_valid("t4_m0_resp", 0, 40);
      req(M_CORE, MEM_READ, 32'h400 + 32'(4 * n), 32'h0, 4'h0);
    end
    wait_valid("t4_m0_last", 0, 40);
    check("t4_m1_served", 64'(valid_cnt[1] - base1), 64'd1);
    check("t4_m1_not_starved", 64'((m0_at_m1 - base0) <= 1), 64'd1);

    // Reset while waiting on memory; the late completion must be ignored.
    resp_delay = 6;
    req(M_CORE, MEM_READ, 32'h600, 32'h0, 4'h0);
    tick();
    wait_fire("t5_fire", 10);
    tick();
    check("t5_in_wait", 64'(dut.state_q), 64'(WAIT));
    reset = 1'b0;
    resp_pending = 1'b0;
    exp_mem.delete();
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t5_no_m0_valid", 64'(m0_if.valid), 64'd0);
      check("t5_no_m1_valid", 64'(m1_if.valid), 64'd0);
    end
    check("t5_m0_ready", 64'(m0_if.ready), 64'd1);
    check("t5_m1_ready", 64'(m1_if.ready), 64'd1);
    check("t5_state_idle", 64'(dut.state_q), 64'(IDLE));

    // Enable while busy is ignored; stray memory_valid in IDLE raises nothing.
    resp_delay = 3;
    req(M_CORE, MEM_READ, 32'h700, 32'h0, 4'hF);
    tick();
    check("t6_busy_ready", 64'(m0_if.ready), 64'd0);
    m0_if.enable = 1'b1;
    m0_if.command = MEM_WRITE;
    m0_if.address = 32'hBAD;
    m0_if.write_data = 32'hFFFF_0000;
    tick();
    m0_if.enable = 1'b0;
    check("t6_still_busy", 64'(m0_if.ready), 64'd0);
    wait_valid("t6_resp", 0, 20);
    tick();
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_stray_m0_valid", 64'(m0_if.valid), 64'd0);
      check("t6_stray_m1_valid", 64'(m1_if.valid), 64'd0);
      check("t6_stray_mem_enable", 64'(mem_if.enable), 64'd0);
    end
    check("t6_state_idle", 64'(dut.state_q), 64'(IDLE));

    check("sb_empty", 64'(exp_mem.size()), 64'd0);
    check("sb_no_pending", 64'(resp_pending), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
